// File: rtl/scm_refill_pkg.sv
// Shared types and constants for the SCM refill write-side controller.
package scm_refill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } refill_state_e;

  // Refill-bus beats packed into one SCM write word.
  localparam int BEATS_PER_WORD = 2;

endpackage : scm_refill_pkg

// File: rtl/scm_refill_writer.sv
// Write-side refill controller for the latch-based SCM: packs 32-bit refill
// beats into 64-bit words and issues one registered SCM write per word.
module scm_refill_writer
  import scm_refill_pkg::*;
#(
  parameter int NB_WAYS     = 4,
  parameter int WADDR_WIDTH = 5,
  parameter int WDATA_WIDTH = 64,
  parameter int BEAT_WIDTH  = 32,
  parameter int LINE_WORDS  = 4,
  parameter int LINE_AW     = WADDR_WIDTH - $clog2(LINE_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   refill_req_i,
  output logic                   refill_gnt_o,
  input  logic [NB_WAYS-1:0]     refill_way_i,
  input  logic [LINE_AW-1:0]     refill_line_i,
  input  logic                   beat_valid_i,
  output logic                   beat_ready_o,
  input  logic [BEAT_WIDTH-1:0]  beat_data_i,
  input  logic                   beat_err_i,
  output logic                   refill_done_o,
  output logic                   refill_err_o,
  output logic [NB_WAYS-1:0]     WriteWay,
  output logic                   WriteEnable,
  output logic [WADDR_WIDTH-1:0] WriteAddr,
  output logic [WDATA_WIDTH-1:0] WriteData
);

  localparam int BEATS_PER_LINE = BEATS_PER_WORD * LINE_WORDS;
  localparam int CNT_W          = $clog2(BEATS_PER_LINE);
  localparam int WORD_SH        = $clog2(LINE_WORDS);

  refill_state_e state_q, state_d;

  logic [NB_WAYS-1:0]     way_q;
  logic [LINE_AW-1:0]     line_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic                   err_q;
  logic [BEAT_WIDTH-1:0]  lo_q;
  logic                   we_q;
  logic [WADDR_WIDTH-1:0] waddr_q;
  logic [WDATA_WIDTH-1:0] wdata_q;

  logic                   grant;
  logic                   beat_fire;
  logic                   odd_beat;
  logic                   last_beat;
  logic [WADDR_WIDTH-1:0] word_addr;

  assign grant     = refill_req_i & refill_gnt_o;
  assign beat_fire = beat_valid_i & beat_ready_o;
  assign odd_beat  = beat_cnt_q[0];
  assign last_beat = (beat_cnt_q == CNT_W'(BEATS_PER_LINE - 1));

  // Word index within the line is the beat count without its pair bit.
  assign word_addr = (WADDR_WIDTH'(line_q) << WORD_SH)
                   | WADDR_WIDTH'(beat_cnt_q >> 1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (grant) state_d = FILL;
      FILL: if (beat_fire && last_beat) state_d = LAST;
      LAST: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    refill_gnt_o  = 1'b0;
    beat_ready_o  = 1'b0;
    refill_done_o = 1'b0;
    refill_err_o  = 1'b0;
    WriteWay      = '0;
    unique case (state_q)
      IDLE: refill_gnt_o = refill_req_i;
      FILL: begin
        beat_ready_o = 1'b1;
        WriteWay     = way_q;
      end
      LAST: WriteWay = way_q;
      DONE: begin
        refill_done_o = 1'b1;
        refill_err_o  = err_q;
        WriteWay      = way_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture, beat packing and the registered SCM write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      way_q      <= '0;
      line_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      lo_q       <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (grant) begin
        way_q      <= refill_way_i;
        line_q     <= refill_line_i;
        beat_cnt_q <= '0;
        err_q      <= 1'b0;
      end
      if (beat_fire) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        err_q      <= err_q | beat_err_i;
        if (!odd_beat) begin
          lo_q <= beat_data_i;
        end else begin
          // Write lands the cycle after the pair completes; error beats still write.
          we_q    <= 1'b1;
          waddr_q <= word_addr;
          wdata_q <= {beat_data_i, lo_q};
        end
      end
    end
  end

  assign WriteEnable = we_q;
  assign WriteAddr   = waddr_q;
  assign WriteData   = wdata_q;

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_way_onehot : assert property (@(posedge clk) disable iff (rst)
    grant |-> $onehot(refill_way_i));

  a_we_spacing : assert property (@(posedge clk) disable iff (rst)
    we_q |=> !we_q);

endmodule : scm_refill_writer

// File: tb/tb_scm_refill_writer.sv
// Directed bench for scm_refill_writer with a behavioural SCM model fed by
// the write port; expected values are hand-derived from the refill protocol.
module tb_scm_refill_writer;

  localparam int NB_WAYS     = 4;
  localparam int WADDR_WIDTH = 5;
  localparam int WDATA_WIDTH = 64;
  localparam int BEAT_WIDTH  = 32;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_AW     = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   refill_req_i;
  logic                   refill_gnt_o;
  logic [NB_WAYS-1:0]     refill_way_i;
  logic [LINE_AW-1:0]     refill_line_i;
  logic                   beat_valid_i;
  logic                   beat_ready_o;
  logic [BEAT_WIDTH-1:0]  beat_data_i;
  logic                   beat_err_i;
  logic                   refill_done_o;
  logic                   refill_err_o;
  logic [NB_WAYS-1:0]     WriteWay;
  logic                   WriteEnable;
  logic [WADDR_WIDTH-1:0] WriteAddr;
  logic [WDATA_WIDTH-1:0] WriteData;

  scm_refill_writer #(
    .NB_WAYS    (NB_WAYS),
    .WADDR_WIDTH(WADDR_WIDTH),
    .WDATA_WIDTH(WDATA_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .LINE_AW    (LINE_AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .refill_req_i (refill_req_i),
    .refill_gnt_o (refill_gnt_o),
    .refill_way_i (refill_way_i),
    .refill_line_i(refill_line_i),
    .beat_valid_i (beat_valid_i),
    .beat_ready_o (beat_ready_o),
    .beat_data_i  (beat_data_i),
    .beat_err_i   (beat_err_i),
    .refill_done_o(refill_done_o),
    .refill_err_o (refill_err_o),
    .WriteWay     (WriteWay),
    .WriteEnable  (WriteEnable),
    .WriteAddr    (WriteAddr),
    .WriteData    (WriteData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records writes/done pulses and updates the SCM model mid-cycle.
  logic [63:0] scm [NB_WAYS][32];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          we_b2b = 0;
  int          wr_cyc [64];
  logic [4:0]  wr_addr [64];
  logic [63:0] wr_data [64];
  logic [3:0]  wr_way [64];
  int          done_cyc = 0;
  logic        done_err = 1'b0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    prev_we <= WriteEnable;
    if (WriteEnable && prev_we) we_b2b <= we_b2b + 1;
    if (WriteEnable && wr_cnt < 64) begin
      wr_cyc[wr_cnt]  <= cyc;
      wr_addr[wr_cnt] <= WriteAddr;
      wr_data[wr_cnt] <= WriteData;
      wr_way[wr_cnt]  <= WriteWay;
      wr_cnt          <= wr_cnt + 1;
      for (int w = 0; w < NB_WAYS; w++)
        if (WriteWay[w]) scm[w][WriteAddr] <= WriteData;
    end
    if (refill_done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      done_err <= refill_err_o;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] scm_rd(input int way, input int raddr);
    logic [63:0] word;
    word = scm[way][raddr / 2];
    return (raddr % 2 == 1) ? word[63:32] : word[31:0];
  endfunction

  int acc_cyc [8];
  int gap_none [8];
  int gap_some [8];

  task automatic start_refill(input logic [3:0] way, input logic [2:0] line, output int g);
    int budget;
    refill_req_i  = 1'b1;
    refill_way_i  = way;
    refill_line_i = line;
    #1;
    budget = 0;
    while (!refill_gnt_o && budget < 20) begin
      step();
      budget++;
    end
    check("grant_seen", refill_gnt_o, 1);
    g = cyc;
  endtask

  task automatic drive_beats(input logic [31:0] base, input int gap[8],
                             input int err_beat, input int nbeats, input string tag);
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < gap[b]; k++) begin
        beat_valid_i = 1'b0;
        step();
      end
      beat_valid_i = 1'b1;
      beat_data_i  = base + 32'(b);
      beat_err_i   = (b == err_beat);
      #1;
      check($sformatf("%s_ready%0d", tag, b), beat_ready_o, 1);
      acc_cyc[b] = cyc;
      step();
    end
    beat_valid_i = 1'b0;
    beat_err_i   = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 30; i++) begin
      if (done_cnt > d0) break;
      step();
    end
    check({tag, "_done_cnt"}, 64'(done_cnt - d0), 1);
  endtask

  // Four writes of a full line: address line*4+i, data {beat 2i+1, beat 2i},
  // issued the cycle after the odd beat of each pair was accepted.
  task automatic check_writes(input int w0, input logic [3:0] way, input int line,
                              input logic [31:0] base, input string tag);
    check({tag, "_wr_cnt"}, 64'(wr_cnt - w0), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[w0+i]), 64'(line * 4 + i));
      check($sformatf("%s_data%0d", tag, i), wr_data[w0+i],
            {base + 32'(2*i + 1), base + 32'(2*i)});
      check($sformatf("%s_way%0d", tag, i), 64'(wr_way[w0+i]), 64'(way));
      check($sformatf("%s_wcyc%0d", tag, i), 64'(wr_cyc[w0+i]), 64'(acc_cyc[2*i+1] + 1));
    end
  endtask

  initial begin
    int g, g2, g3, w0, d0;
    gap_none = '{0, 0, 0, 0, 0, 0, 0, 0};
    gap_some = '{0, 1, 2, 0, 0, 1, 0, 3};

    rst           = 1'b1;
    refill_req_i  = 1'b0;
    refill_way_i  = '0;
    refill_line_i = '0;
    beat_valid_i  = 1'b0;
    beat_data_i   = '0;
    beat_err_i    = 1'b0;
    step();
    step();

    // Reset state
    check("rst_gnt",   refill_gnt_o,  0);
    check("rst_ready", beat_ready_o,  0);
    check("rst_done",  refill_done_o, 0);
    check("rst_err",   refill_err_o,  0);
    check("rst_wway",  64'(WriteWay), 0);
    check("rst_we",    WriteEnable,   0);
    check("rst_waddr", 64'(WriteAddr), 0);
    check("rst_wdata", WriteData,     0);
    refill_req_i = 1'b1;
    #1;
    check("rst_idle_gnt", refill_gnt_o, 1);
    refill_req_i = 1'b0;
    step();
    rst = 1'b0;

    // Basic refill: way 1, line 3, back-to-back beats
    w0 = wr_cnt; d0 = done_cnt;
    start_refill(4'b0010, 3'd3, g);
    step();
    refill_req_i = 1'b0;
    drive_beats(32'h1000_0000, gap_none, -1, 8, "basic");
    wait_done(d0, "basic");
    check_writes(w0, 4'b0010, 3, 32'h1000_0000, "basic");
    for (int i = 0; i < 4; i++)
      check($sformatf("basic_spec_wcyc%0d", i), 64'(wr_cyc[w0+i]), 64'(g + 3 + 2*i));
    check("basic_done_cyc", 64'(done_cyc), 64'(g + 10));
    check("basic_done_err", done_err, 0);
    for (int a = 24; a < 32; a++)
      check($sformatf("basic_rd%0d", a), 64'(scm_rd(1, a)), 64'(32'h1000_0000 + 32'(a - 24)));

    // Stalled refill into way 2: same contents, done two cycles after last beat
    w0 = wr_cnt; d0 = done_cnt;
    start_refill(4'b0100, 3'd3, g);
    step();
    refill_req_i = 1'b0;
    drive_beats(32'h1000_0000, gap_some, -1, 8, "gaps");
    wait_done(d0, "gaps");
    check_writes(w0, 4'b0100, 3, 32'h1000_0000, "gaps");
    check("gaps_done_cyc", 64'(done_cyc), 64'(acc_cyc[7] + 2));
    for (int a = 24; a < 32; a++)
      check($sformatf("gaps_rd%0d", a), 64'(scm_rd(2, a)), 64'(32'h1000_0000 + 32'(a - 24)));

    // Error on beat 5: all writes still happen, error reported with done
    w0 = wr_cnt; d0 = done_cnt;
    start_refill(4'b1000, 3'd1, g);
    step();
    refill_req_i = 1'b0;
    drive_beats(32'h2000_0000, gap_none, 5, 8, "err");
    wait_done(d0, "err");
    check_writes(w0, 4'b1000, 1, 32'h2000_0000, "err");
    check("err_done_err", done_err, 1);

    // Reset in the cycle after beat 3: only the two completed words are written
    w0 = wr_cnt; d0 = done_cnt;
    start_refill(4'b0100, 3'd0, g);
    step();
    refill_req_i = 1'b0;
    drive_beats(32'h4000_0000, gap_none, -1, 4, "abort");
    rst          = 1'b1;
    beat_valid_i = 1'b1;
    beat_data_i  = 32'h4000_0004;
    step();
    rst          = 1'b0;
    beat_valid_i = 1'b0;
    #1;
    check("abort_we",    WriteEnable,    0);
    check("abort_wway",  64'(WriteWay),  0);
    check("abort_ready", beat_ready_o,   0);
    check("abort_done",  refill_done_o,  0);
    check("abort_waddr", 64'(WriteAddr), 0);
    check("abort_wdata", WriteData,      0);
    check("abort_wr_cnt", 64'(wr_cnt - w0), 2);
    check("abort_no_done", 64'(done_cnt - d0), 0);
    g = cyc;

    // Request granted right after reset, held high across done
    w0 = wr_cnt; d0 = done_cnt;
    start_refill(4'b0001, 3'd2, g2);
    check("post_rst_grant_cyc", 64'(g2), 64'(g));
    step();
    drive_beats(32'h3000_0000, gap_none, -1, 8, "held");
    beat_valid_i = 1'b1;
    beat_data_i  = 32'hDEAD_BEEF;
    step();
    check("held_done",       refill_done_o, 1);
    check("held_done_err",   refill_err_o,  0);
    check("held_done_ready", beat_ready_o,  0);
    check("held_done_gnt",   refill_gnt_o,  0);
    refill_way_i  = 4'b1000;
    refill_line_i = 3'd5;
    step();
    check("held_idle_gnt",   refill_gnt_o, 1);
    check("held_idle_ready", beat_ready_o, 0);
    g3 = cyc;
    check("held_regrant_cyc", 64'(g3), 64'(g2 + 11));
    check("held_done_cnt", 64'(done_cnt - d0), 1);
    check("held_done_cyc", 64'(done_cyc), 64'(g2 + 10));
    check_writes(w0, 4'b0001, 2, 32'h3000_0000, "held");
    for (int i = 0; i < 4; i++)
      check($sformatf("held_spec_wcyc%0d", i), 64'(wr_cyc[w0+i]), 64'(g2 + 3 + 2*i));
    step();
    refill_req_i = 1'b0;
    w0 = wr_cnt; d0 = done_cnt;
    drive_beats(32'h5000_0000, gap_none, -1, 8, "second");
    wait_done(d0, "second");
    check_writes(w0, 4'b1000, 5, 32'h5000_0000, "second");
    check("second_first_beat_cyc", 64'(acc_cyc[0]), 64'(g3 + 1));
    check("second_done_err", done_err, 0);

    check("we_never_b2b", 64'(we_b2b), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_scm_refill_writer
